// File: rtl/weight_dispatcher.sv
// rtl/weight_dispatcher.sv - stages one kernel of weights, then flushes and bursts it to each PE in turn
module weight_dispatcher #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 16,
  parameter int NUM_PE       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            kernel_size,
  input  logic [7:0]            num_kernels,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_PE-1:0]     w_busy,
  output logic [NUM_PE-1:0]     w_flush,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [7:0]            pe_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [7:0] MAX_K = 8'(BUFFER_DEPTH);
  localparam logic [7:0] MAX_N = 8'(NUM_PE);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_FLUSH, S_BURST, S_NEXT} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [7:0]            count, k_reg, n_reg, burst_cnt;
  logic [NUM_PE-1:0]     pe_sel;
  logic                  push, cfg_ok, last_pe, last_beat, target_busy;

  always_comb begin
    pe_sel = '0;
    for (int i = 0; i < NUM_PE; i++) pe_sel[i] = (pe_idx == 8'(i));
  end

  assign cfg_ok      = (kernel_size != 8'd0) && (kernel_size <= MAX_K) &&
                       (num_kernels != 8'd0) && (num_kernels <= MAX_N);
  // count is registered, so s_ready never depends on s_valid
  assign s_ready     = (state == S_FILL) && (count < k_reg);
  assign push        = s_valid && s_ready;
  assign target_busy = |(w_busy & pe_sel);
  assign last_pe     = (pe_idx == n_reg - 8'd1);
  assign last_beat   = (burst_cnt == k_reg - 8'd1);
  assign w_flush     = (state == S_FLUSH) ? pe_sel : '0;
  assign w_data      = (state == S_BURST) ? mem[rd_ptr] : '0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_NEXT) && last_pe;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && cfg_ok) state_nx = S_FILL;
      S_FILL:  if (push && (count + 8'd1 == k_reg)) state_nx = S_WAIT;
      S_WAIT:  if (!target_busy) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_BURST;
      S_BURST: if (last_beat) state_nx = S_NEXT;
      S_NEXT:  state_nx = last_pe ? S_IDLE : S_FILL;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      k_reg     <= '0;
      n_reg     <= '0;
      burst_cnt <= '0;
      pe_idx    <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        k_reg <= kernel_size;
        n_reg <= num_kernels;
        if (cfg_ok) begin
          cfg_err <= 1'b0;
          pe_idx  <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        count  <= count + 8'd1;
      end
      if (state == S_FLUSH) burst_cnt <= '0;
      // a full burst pops exactly K words, leaving the FIFO empty for the next FILL
      if (state == S_BURST) begin
        rd_ptr    <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        count     <= count - 8'd1;
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (state == S_NEXT && !last_pe) pe_idx <= pe_idx + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_weight_dispatcher.sv
// tb/tb_weight_dispatcher.sv - randomized scoreboard bench for weight_dispatcher
module tb_weight_dispatcher;
  localparam int DW = 16;
  localparam int NUM_PE = 4;

  logic          clk, rstn, start;
  logic [7:0]    kernel_size, num_kernels;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [NUM_PE-1:0] w_busy, w_flush;
  logic [DW-1:0] w_data;
  logic [7:0]    pe_idx;
  logic          busy, done, cfg_err;

  weight_dispatcher #(.DATA_WIDTH(DW), .BUFFER_DEPTH(16), .NUM_PE(NUM_PE)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kernel_size(kernel_size),
    .num_kernels(num_kernels), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .w_busy(w_busy), .w_flush(w_flush), .w_data(w_data), .pe_idx(pe_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    bit                is_flush;
    logic [NUM_PE-1:0] mask;
    int                len;
    bit                last;
    logic [DW-1:0]     data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] words[$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            valid_mode = 0;
  bit            busy_rand = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // source driver: presents words at negedge, retires them after an observed handshake
  initial begin : driver
    bit xfer_pending;
    bit phase;
    bit want;
    logic [DW-1:0] dummy;
    s_valid = 0;
    s_data = '0;
    xfer_pending = 0;
    phase = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        xfer_pending = 0;
        s_valid = 0;
      end else begin
        if (xfer_pending && src_q.size() > 0) dummy = src_q.pop_front();
        phase = ~phase;
        case (valid_mode)
          0: want = 1;
          1: want = phase;
          default: want = 1'($urandom_range(0, 1));
        endcase
        s_valid = want && (src_q.size() > 0);
        s_data = s_valid ? src_q[0] : '0;
        xfer_pending = s_valid && s_ready;
      end
    end
  end

  initial begin : busy_driver
    forever begin
      @(negedge clk);
      if (busy_rand) w_busy = NUM_PE'($urandom_range(0, (1 << NUM_PE) - 1));
    end
  end

  // monitor: compares DUT outputs to the scoreboard queue, away from the active edge
  initial begin : monitor
    exp_t e;
    int   burst_left;
    bit   in_next;
    bit   last_k;
    burst_left = 0;
    in_next = 0;
    last_k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        exp_q.delete();
        burst_left = 0;
        in_next = 0;
      end else if (burst_left > 0) begin
        chk("burst_no_flush", 32'(w_flush), 32'd0);
        chk("burst_no_done", 32'(done), 32'd0);
        if (exp_q.size() == 0 || exp_q[0].is_flush) begin
          checks++;
          errors++;
          $display("FAIL burst_word: got %0h but no data word expected", w_data);
        end else begin
          e = exp_q.pop_front();
          chk("burst_word", 32'(w_data), 32'(e.data));
        end
        burst_left--;
        in_next = (burst_left == 0);
      end else if (in_next) begin
        chk("next_done", 32'(done), 32'(last_k));
        chk("next_no_flush", 32'(w_flush), 32'd0);
        chk("next_wdata", 32'(w_data), 32'd0);
        if (done) done_cnt++;
        in_next = 0;
      end else begin
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wdata", 32'(w_data), 32'd0);
        if (w_flush != '0) begin
          if (exp_q.size() == 0 || !exp_q[0].is_flush) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flush: got %0h expected none", w_flush);
          end else begin
            e = exp_q.pop_front();
            chk("flush_mask", 32'(w_flush), 32'(e.mask));
            burst_left = e.len;
            last_k = e.last;
          end
        end
      end
    end
  end

  // reference model: kernel p goes to PE p, words p*K..p*K+K-1 in arrival order
  task automatic load(input int k, input int n);
    exp_t e;
    for (int p = 0; p < n; p++) begin
      e.is_flush = 1; e.mask = NUM_PE'(1 << p); e.len = k; e.last = (p == n - 1); e.data = '0;
      exp_q.push_back(e);
      for (int j = 0; j < k; j++) begin
        e.is_flush = 0; e.mask = '0; e.len = 0; e.last = 0; e.data = words[p * k + j];
        exp_q.push_back(e);
      end
    end
    foreach (words[i]) src_q.push_back(words[i]);
  endtask

  task automatic pulse_start(input int k, input int n);
    kernel_size = 8'(k);
    num_kernels = 8'(n);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    chk("idle_reached", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_cmd(input int k, input int n, input int mode, output int cyc);
    valid_mode = mode;
    load(k, n);
    pulse_start(k, n);
    wait_idle(cyc);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cyc, d0, guard;
    rstn = 0; start = 0; kernel_size = 0; num_kernels = 0; w_busy = '0;
    repeat (3) @(negedge clk);
    rstn = 1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_w_flush", 32'(w_flush), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_pe_idx", 32'(pe_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);

    // basic dispatch, back-to-back input
    words = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66};
    d0 = done_cnt;
    run_cmd(3, 2, 0, cyc);
    chk("basic_cycles", 32'(cyc), 32'd18);
    chk("basic_done_once", 32'(done_cnt - d0), 32'd1);

    // backpressure: the 5th offered word must stay with the source
    words = '{16'hB1, 16'hB2, 16'hB3, 16'hB4, 16'hB5};
    valid_mode = 1;
    load(4, 1);
    pulse_start(4, 1);
    wait_idle(cyc);
    chk("bp_extra_word_kept", 32'(src_q.size()), 32'd1);
    src_q.delete();
    @(negedge clk);

    // busy hold: other PEs busy too, only PE0's bit matters
    w_busy = 4'b1111;
    words = '{16'hA1, 16'hA2};
    valid_mode = 0;
    load(2, 1);
    pulse_start(2, 1);
    guard = 0;
    while (s_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_no_flush", 32'(w_flush), 32'd0);
      @(negedge clk);
    end
    w_busy = 4'b1110;
    @(negedge clk);
    chk("flush_after_release", 32'(w_flush), 32'b0001);
    wait_idle(cyc);
    w_busy = '0;

    // configuration errors
    pulse_start(0, 1);
    chk("cfg_k0_err", 32'(cfg_err), 32'd1);
    chk("cfg_k0_busy", 32'(busy), 32'd0);
    chk("cfg_k0_ready", 32'(s_ready), 32'd0);
    pulse_start(17, 1);
    chk("cfg_k17_err", 32'(cfg_err), 32'd1);
    chk("cfg_k17_busy", 32'(busy), 32'd0);
    pulse_start(4, 5);
    chk("cfg_n5_err", 32'(cfg_err), 32'd1);
    chk("cfg_n5_busy", 32'(busy), 32'd0);
    chk("cfg_n5_ready", 32'(s_ready), 32'd0);
    words = '{16'h5A};
    load(1, 1);
    pulse_start(1, 1);
    chk("cfg_cleared", 32'(cfg_err), 32'd0);
    wait_idle(cyc);

    // wrap at maximum depth
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back(16'(i));
    run_cmd(16, 4, 2, cyc);

    // randomized commands with random input stalls and random downstream busy
    busy_rand = 1;
    for (int it = 0; it < 6; it++) begin
      int k, n;
      k = $urandom_range(1, 16);
      n = $urandom_range(1, NUM_PE);
      words.delete();
      for (int i = 0; i < k * n; i++) words.push_back(16'($urandom));
      run_cmd(k, n, 2, cyc);
    end
    busy_rand = 0;
    w_busy = '0;
    @(negedge clk);

    // reset during burst cycle 2
    words = '{16'hC1, 16'hC2, 16'hC3, 16'hC4};
    valid_mode = 0;
    load(4, 1);
    pulse_start(4, 1);
    guard = 0;
    while (w_flush == '0 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("mid_flush_seen", 32'(w_flush), 32'b0001);
    repeat (3) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    chk("mrst_s_ready", 32'(s_ready), 32'd0);
    chk("mrst_w_flush", 32'(w_flush), 32'd0);
    chk("mrst_w_data", 32'(w_data), 32'd0);
    chk("mrst_pe_idx", 32'(pe_idx), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_cfg_err", 32'(cfg_err), 32'd0);
    rstn = 1;
    src_q.delete();
    @(negedge clk);
    words = '{16'hD1, 16'hD2};
    d0 = done_cnt;
    run_cmd(2, 1, 0, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd7);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
